aemb_wb_arbiter: RTL and testbench

- Two-master, one-slave WISHBONE arbiter that lets the core's instruction bus (iwb) and data bus (dwb) share a single memory port (mwb).
- Sits between the core's iwb/dwb outputs and a unified memory or bus bridge.
- Round-robin grant, one transaction in flight, registered slave-side outputs, and a watchdog that terminates stalled cycles.

---
 rtl/aemb_wb_arbiter.sv | 117 +++++++++++
 tb/tb_aemb_wb_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aemb_wb_arbiter.sv
// Two-master (iwb/dwb) to one-slave WISHBONE arbiter: round-robin grant, one cycle in flight, watchdog abort.
// Latency: stb to mwb_stb_o 1 cycle; ack to master 1 cycle after mwb_ack_i; requests stall while BUSY/ACK.
module aemb_wb_arbiter #(
  parameter int ISIZ = 32,
  parameter int DSIZ = 32,
  parameter int TMO  = 255
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  input  logic            iwb_stb_i,
  input  logic [ISIZ-1:0] iwb_adr_i,
  output logic [31:0]     iwb_dat_o,
  output logic            iwb_ack_o,
  input  logic            dwb_stb_i,
  input  logic            dwb_we_i,
  input  logic [DSIZ-1:0] dwb_adr_i,
  input  logic [31:0]     dwb_dat_i,
  output logic [31:0]     dwb_dat_o,
  output logic            dwb_ack_o,
  output logic            mwb_stb_o,
  output logic            mwb_we_o,
  output logic [31:0]     mwb_adr_o,
  output logic [31:0]     mwb_dat_o,
  input  logic [31:0]     mwb_dat_i,
  input  logic            mwb_ack_i,
  output logic            err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  localparam logic [7:0] TmoLim = 8'(TMO);
  localparam logic       TmoEn  = (TMO != 0);

  logic [1:0] rState;
  logic [7:0] rCnt;
  logic       rLastI;   // last grant went to iwb
  logic       rGntD;    // current transaction belongs to dwb
  logic       grantD;
  logic       tmoHit;

  // dwb wins a tie unless it was served last
  assign grantD = dwb_stb_i && (!iwb_stb_i || rLastI);
  assign tmoHit = TmoEn && (rCnt == TmoLim);

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      rState    <= IDLE;
      rCnt      <= 8'd0;
      rLastI    <= 1'b1;
      rGntD     <= 1'b0;
      iwb_dat_o <= 32'd0;
      iwb_ack_o <= 1'b0;
      dwb_dat_o <= 32'd0;
      dwb_ack_o <= 1'b0;
      mwb_stb_o <= 1'b0;
      mwb_we_o  <= 1'b0;
      mwb_adr_o <= 32'd0;
      mwb_dat_o <= 32'd0;
      err_o     <= 1'b0;
    end else begin
      case (rState)
        IDLE: begin
          rCnt <= 8'd0;
          if (grantD) begin
            mwb_stb_o <= 1'b1;
            mwb_we_o  <= dwb_we_i;
            mwb_adr_o <= 32'(dwb_adr_i);
            mwb_dat_o <= dwb_dat_i;
            rGntD     <= 1'b1;
            rLastI    <= 1'b0;
            rState    <= BUSY;
          end else if (iwb_stb_i) begin
            mwb_stb_o <= 1'b1;
            mwb_we_o  <= 1'b0;
            mwb_adr_o <= 32'(iwb_adr_i);
            mwb_dat_o <= 32'd0;
            rGntD     <= 1'b0;
            rLastI    <= 1'b1;
            rState    <= BUSY;
          end
        end

        BUSY: begin
          if (mwb_ack_i || tmoHit) begin
            // a real ack beats a simultaneous timeout
            mwb_stb_o <= 1'b0;
            mwb_we_o  <= 1'b0;
            rCnt      <= 8'd0;
            err_o     <= !mwb_ack_i;
            if (rGntD) begin
              dwb_ack_o <= 1'b1;
              dwb_dat_o <= mwb_ack_i ? mwb_dat_i : 32'd0;
            end else begin
              iwb_ack_o <= 1'b1;
              iwb_dat_o <= mwb_ack_i ? mwb_dat_i : 32'd0;
            end
            rState <= ACK;
          end else begin
            rCnt <= rCnt + 8'd1;
          end
        end

        ACK: begin
          iwb_ack_o <= 1'b0;
          dwb_ack_o <= 1'b0;
          err_o     <= 1'b0;
          rState    <= IDLE;
        end

        default: rState <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aemb_wb_arbiter.sv
// Directed bench for aemb_wb_arbiter: a TMO=4 instance for most scenarios, a TMO=0 instance for the long-wait case.
module tb_aemb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic        iwbStb, dwbStb, dwbWe;
  logic [31:0] iwbAdr, dwbAdr, dwbDatW, slvDat;
  logic        manAck, autoAck, mwbAck;

  logic [31:0] iwbDat, dwbDat, mwbAdr, mwbDat;
  logic        iwbAck, dwbAck, mwbStb, mwbWe, err;
  logic [31:0] iwbDat0, dwbDat0, mwbAdr0, mwbDat0;
  logic        iwbAck0, dwbAck0, mwbStb0, mwbWe0, err0;

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  // zero-wait slave follows the TMO=4 instance's strobe
  assign mwbAck = autoAck ? mwbStb : manAck;

  aemb_wb_arbiter #(.ISIZ(32), .DSIZ(32), .TMO(4)) dut (
    .sys_clk_i(clk), .sys_rst_i(rstN),
    .iwb_stb_i(iwbStb), .iwb_adr_i(iwbAdr), .iwb_dat_o(iwbDat), .iwb_ack_o(iwbAck),
    .dwb_stb_i(dwbStb), .dwb_we_i(dwbWe), .dwb_adr_i(dwbAdr), .dwb_dat_i(dwbDatW),
    .dwb_dat_o(dwbDat), .dwb_ack_o(dwbAck),
    .mwb_stb_o(mwbStb), .mwb_we_o(mwbWe), .mwb_adr_o(mwbAdr), .mwb_dat_o(mwbDat),
    .mwb_dat_i(slvDat), .mwb_ack_i(mwbAck), .err_o(err)
  );

  aemb_wb_arbiter #(.ISIZ(32), .DSIZ(32), .TMO(0)) dut0 (
    .sys_clk_i(clk), .sys_rst_i(rstN),
    .iwb_stb_i(iwbStb), .iwb_adr_i(iwbAdr), .iwb_dat_o(iwbDat0), .iwb_ack_o(iwbAck0),
    .dwb_stb_i(dwbStb), .dwb_we_i(dwbWe), .dwb_adr_i(dwbAdr), .dwb_dat_i(dwbDatW),
    .dwb_dat_o(dwbDat0), .dwb_ack_o(dwbAck0),
    .mwb_stb_o(mwbStb0), .mwb_we_o(mwbWe0), .mwb_adr_o(mwbAdr0), .mwb_dat_o(mwbDat0),
    .mwb_dat_i(slvDat), .mwb_ack_i(mwbAck), .err_o(err0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstN = 1'b0; iwbStb = 1'b0; dwbStb = 1'b0; dwbWe = 1'b0;
    iwbAdr = 32'd0; dwbAdr = 32'd0; dwbDatW = 32'd0; slvDat = 32'd0;
    manAck = 1'b0; autoAck = 1'b0;
    tick(); tick();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; iwbStb = 1'b0; dwbStb = 1'b0; dwbWe = 1'b0;
    iwbAdr = 32'd0; dwbAdr = 32'd0; dwbDatW = 32'd0; slvDat = 32'd0;
    manAck = 1'b0; autoAck = 1'b0;
    tick();
    nCmp++;
    if ({mwbStb, mwbWe, iwbAck, dwbAck, err} !== 5'b0) begin
      nErr++; $display("FAIL reset_ctrl: stb/we/iack/dack/err=%b want 00000", {mwbStb, mwbWe, iwbAck, dwbAck, err});
    end
    nCmp++;
    if ({mwbAdr, mwbDat} !== 64'd0) begin
      nErr++; $display("FAIL reset_mwb_bus: adr=%h dat=%h want 0", mwbAdr, mwbDat);
    end
    nCmp++;
    if ({iwbDat, dwbDat} !== 64'd0) begin
      nErr++; $display("FAIL reset_master_dat: idat=%h ddat=%h want 0", iwbDat, dwbDat);
    end
    tick();
    rstN = 1'b1;
  endtask

  task automatic test_read();
    doReset();
    iwbStb = 1'b1; iwbAdr = 32'h100;
    tick();
    nCmp++;
    if ({mwbStb, mwbWe, mwbAdr} !== {1'b1, 1'b0, 32'h100}) begin
      nErr++; $display("FAIL read_grant: stb=%b we=%b adr=%h want 1 0 00000100", mwbStb, mwbWe, mwbAdr);
    end
    tick();
    nCmp++;
    if (mwbStb !== 1'b1 || iwbAck !== 1'b0) begin
      nErr++; $display("FAIL read_busy2: stb=%b iack=%b want 1 0", mwbStb, iwbAck);
    end
    manAck = 1'b1; slvDat = 32'hB800_0010;
    tick();
    manAck = 1'b0;
    nCmp++;
    if ({iwbAck, dwbAck, mwbStb} !== 3'b100 || iwbDat !== 32'hB800_0010) begin
      nErr++; $display("FAIL read_ack: iack=%b dack=%b stb=%b idat=%h want 1 0 0 b8000010", iwbAck, dwbAck, mwbStb, iwbDat);
    end
    tick();
    iwbStb = 1'b0;
    nCmp++;
    if ({iwbAck, dwbAck} !== 2'b00 || iwbDat !== 32'hB800_0010) begin
      nErr++; $display("FAIL read_pulse_end: iack=%b dack=%b idat=%h want 0 0 b8000010", iwbAck, dwbAck, iwbDat);
    end
  endtask

  task automatic test_alternate();
    logic        expD;
    logic [31:0] expAdr;
    doReset();
    slvDat = 32'h0A0A_0A0A; autoAck = 1'b1;
    iwbStb = 1'b1; iwbAdr = 32'h200;
    dwbStb = 1'b1; dwbAdr = 32'h300; dwbWe = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      expD   = ((k / 3) % 2) == 0;
      expAdr = expD ? 32'h300 : 32'h200;
      nCmp++;
      case (k % 3)
        0: if (mwbStb !== 1'b1 || mwbAdr !== expAdr || iwbAck !== 1'b0 || dwbAck !== 1'b0) begin
             nErr++; $display("FAIL alt_grant k=%0d: stb=%b adr=%h acks=%b%b want 1 %h 00", k, mwbStb, mwbAdr, iwbAck, dwbAck, expAdr);
           end
        1: if (mwbStb !== 1'b0 || dwbAck !== expD || iwbAck !== !expD) begin
             nErr++; $display("FAIL alt_ack k=%0d: stb=%b dack=%b iack=%b want 0 %b %b", k, mwbStb, dwbAck, iwbAck, expD, !expD);
           end
        default: if (mwbStb !== 1'b0 || iwbAck !== 1'b0 || dwbAck !== 1'b0) begin
             nErr++; $display("FAIL alt_idle k=%0d: stb=%b acks=%b%b want 0 00", k, mwbStb, iwbAck, dwbAck);
           end
      endcase
    end
    iwbStb = 1'b0; dwbStb = 1'b0;
    tick(); tick(); tick();
    autoAck = 1'b0;
  endtask

  task automatic test_back_to_back_write();
    doReset();
    autoAck = 1'b1; slvDat = 32'h1234_5678;
    dwbStb = 1'b1; dwbWe = 1'b1; dwbAdr = 32'h8000_0004; dwbDatW = 32'hDEAD_BEEF;
    tick();
    nCmp++;
    if ({mwbStb, mwbWe, mwbAdr, mwbDat} !== {1'b1, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF}) begin
      nErr++; $display("FAIL write_grant: stb=%b we=%b adr=%h dat=%h want 1 1 80000004 deadbeef", mwbStb, mwbWe, mwbAdr, mwbDat);
    end
    tick();
    nCmp++;
    if ({dwbAck, iwbAck, mwbStb, mwbWe} !== 4'b1000 || dwbDat !== 32'h1234_5678) begin
      nErr++; $display("FAIL write_ack: dack=%b iack=%b stb=%b we=%b ddat=%h want 1 0 0 0 12345678", dwbAck, iwbAck, mwbStb, mwbWe, dwbDat);
    end
    tick();
    dwbStb = 1'b0; dwbWe = 1'b0;
    nCmp++;
    if (dwbAck !== 1'b0 || mwbStb !== 1'b0) begin
      nErr++; $display("FAIL write_end: dack=%b stb=%b want 0 0", dwbAck, mwbStb);
    end
    autoAck = 1'b0;
  endtask

  task automatic test_timeout();
    int   highCnt;
    logic done;
    doReset();
    autoAck = 1'b1; slvDat = 32'h5555_AAAA;
    iwbStb = 1'b1; iwbAdr = 32'h40;
    tick(); tick();
    iwbStb = 1'b0;
    nCmp++;
    if (iwbDat !== 32'h5555_AAAA) begin
      nErr++; $display("FAIL tmo_preload: idat=%h want 5555aaaa", iwbDat);
    end
    tick();
    autoAck = 1'b0; manAck = 1'b0;
    iwbStb = 1'b1; iwbAdr = 32'h44;
    highCnt = 0; done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!done) begin
        tick();
        if (mwbStb) highCnt++;
        else if (highCnt > 0) begin
          done = 1'b1;
          nCmp++;
          if ({iwbAck, dwbAck, err} !== 3'b101 || iwbDat !== 32'd0) begin
            nErr++; $display("FAIL tmo_abort: iack=%b dack=%b err=%b idat=%h want 1 0 1 00000000", iwbAck, dwbAck, err, iwbDat);
          end
        end
      end
    end
    nCmp++;
    if (!done || highCnt != 5) begin
      nErr++; $display("FAIL tmo_stb_cycles: done=%b high=%0d want 1 5", done, highCnt);
    end
    iwbStb = 1'b0;
    tick();
    nCmp++;
    if ({iwbAck, err} !== 2'b00) begin
      nErr++; $display("FAIL tmo_pulse_end: iack=%b err=%b want 0 0", iwbAck, err);
    end
    autoAck = 1'b1; slvDat = 32'h0000_0077;
    dwbStb = 1'b1; dwbAdr = 32'h900;
    tick();
    nCmp++;
    if (mwbStb !== 1'b1 || mwbAdr !== 32'h900) begin
      nErr++; $display("FAIL tmo_next_grant: stb=%b adr=%h want 1 00000900", mwbStb, mwbAdr);
    end
    tick();
    dwbStb = 1'b0;
    nCmp++;
    if ({dwbAck, err} !== 2'b10 || dwbDat !== 32'h77) begin
      nErr++; $display("FAIL tmo_next_ack: dack=%b err=%b ddat=%h want 1 0 00000077", dwbAck, err, dwbDat);
    end
    tick();
    autoAck = 1'b0;
  endtask

  task automatic test_reset_busy();
    doReset();
    iwbStb = 1'b1; iwbAdr = 32'h500;
    tick();
    nCmp++;
    if (mwbStb !== 1'b1 || mwbAdr !== 32'h500) begin
      nErr++; $display("FAIL rstb_grant: stb=%b adr=%h want 1 00000500", mwbStb, mwbAdr);
    end
    rstN = 1'b0; dwbStb = 1'b1; dwbAdr = 32'h600;
    tick();
    rstN = 1'b1;
    nCmp++;
    if ({mwbStb, mwbWe, iwbAck, dwbAck, err} !== 5'b0 || {mwbAdr, mwbDat} !== 64'd0) begin
      nErr++; $display("FAIL rstb_clear: ctrl=%b adr=%h dat=%h want 00000 0 0", {mwbStb, mwbWe, iwbAck, dwbAck, err}, mwbAdr, mwbDat);
    end
    tick();
    nCmp++;
    if (mwbStb !== 1'b1 || mwbAdr !== 32'h600 || iwbAck !== 1'b0) begin
      nErr++; $display("FAIL rstb_dwb_first: stb=%b adr=%h iack=%b want 1 00000600 0", mwbStb, mwbAdr, iwbAck);
    end
    autoAck = 1'b1;
    tick();
    iwbStb = 1'b0; dwbStb = 1'b0;
    tick(); tick();
    autoAck = 1'b0;
  endtask

  task automatic test_no_timeout();
    logic bad;
    doReset();
    iwbStb = 1'b1; iwbAdr = 32'h700;
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (err0 !== 1'b0 || mwbStb0 !== 1'b1 || iwbAck0 !== 1'b0) bad = 1'b1;
    end
    nCmp++;
    if (bad) begin
      nErr++; $display("FAIL notmo_wait: err/abort seen during 300-cycle stall, got 1 want 0");
    end
    manAck = 1'b1; slvDat = 32'hCAFE_F00D;
    tick();
    manAck = 1'b0;
    nCmp++;
    if ({iwbAck0, err0} !== 2'b10 || iwbDat0 !== 32'hCAFE_F00D) begin
      nErr++; $display("FAIL notmo_ack: iack=%b err=%b idat=%h want 1 0 cafef00d", iwbAck0, err0, iwbDat0);
    end
    iwbStb = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_alternate();
    test_back_to_back_write();
    test_timeout();
    test_reset_busy();
    test_no_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
